// File: rtl/vga_timing_sched.sv
// rtl/vga_timing_sched.sv - VGA sync/active-pixel timing with frame-aligned display mode scheduling
// Mode changes (request port or auto-rotation) take effect only together with FRAME_START.
module vga_timing_sched #(
    parameter int H_ACT        = 1024,
    parameter int H_FP         = 24,
    parameter int H_SYNC       = 136,
    parameter int H_BP         = 160,
    parameter int V_ACT        = 768,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 29,
    parameter int FRM_PER_MODE = 60
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic       ENABLE,
    input  logic       AUTO_EN,
    input  logic       MODE_REQ_VALID,
    input  logic [1:0] MODE_REQ,
    output logic       MODE_REQ_READY,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VGA_IF_RGBEN,
    output logic       FRAME_START,
    output logic [1:0] MODE
);

    localparam logic [10:0] H_LAST   = 11'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT_W  = 11'(H_ACT);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACT);
    localparam logic [10:0] HS_BEG   = 11'(H_ACT + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACT + V_FP + V_SYNC);
    localparam logic [7:0]  F_LAST   = 8'(FRM_PER_MODE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [10:0] h_q;
    logic [10:0] v_q;
    logic        b_q;
    logic [1:0]  pend_q;
    logic [7:0]  f_q;
    logic        h_last;
    logic        v_last;
    logic        apply;
    logic        accept;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    // b_q marks the cycle holding (0,0) right after a wrap; acting on it lines MODE up with FRAME_START.
    assign apply  = b_q & ENABLE;

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q          <= '0;
            v_q          <= '0;
            b_q          <= 1'b0;
            HSYNC        <= 1'b1;
            VSYNC        <= 1'b1;
            VGA_IF_RGBEN <= 1'b0;
            FRAME_START  <= 1'b0;
        end else if (!ENABLE) begin
            h_q          <= '0;
            v_q          <= '0;
            b_q          <= 1'b0;
            HSYNC        <= 1'b1;
            VSYNC        <= 1'b1;
            VGA_IF_RGBEN <= 1'b0;
            FRAME_START  <= 1'b0;
        end else begin
            VGA_IF_RGBEN <= (h_q < H_ACT_W) && (v_q < V_ACT_W);
            HSYNC        <= !((h_q >= HS_BEG) && (h_q < HS_END));
            VSYNC        <= !((v_q >= VS_BEG) && (v_q < VS_END));
            FRAME_START  <= (h_q == 11'd0) && (v_q == 11'd0);
            b_q          <= h_last && v_last;
            h_q          <= h_last ? 11'd0 : h_q + 11'd1;
            if (h_last) begin
                v_q <= v_last ? 11'd0 : v_q + 11'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        MODE_REQ_READY = (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (MODE_REQ_VALID) begin
                    accept  = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (apply) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pend_q  <= 2'd0;
            f_q     <= 8'd0;
            MODE    <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pend_q <= MODE_REQ;
            end
            // A request that was already pending beats rotation; one accepted on this cycle waits.
            if (apply) begin
                if (state_q == ST_PEND) begin
                    MODE <= pend_q;
                    f_q  <= 8'd0;
                end else if (AUTO_EN) begin
                    if (f_q == F_LAST) begin
                        MODE <= MODE + 2'd1;
                        f_q  <= 8'd0;
                    end else begin
                        f_q <= f_q + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_sched.sv
// tb/tb_vga_timing_sched.sv - directed vector bench for vga_timing_sched on a 16x8 timing grid
// Grid: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), frame = 128 clocks, 2 frames per mode.
module tb_vga_timing_sched;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       auto_en;
    logic       req_valid;
    logic [1:0] req;
    logic       req_ready;
    logic       hsync;
    logic       vsync;
    logic       rgben;
    logic       frame_start;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_sched #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .FRM_PER_MODE(2)
    ) dut (
        .VGA_CLK        (clk),
        .RST_N          (rst_n),
        .ENABLE         (enable),
        .AUTO_EN        (auto_en),
        .MODE_REQ_VALID (req_valid),
        .MODE_REQ       (req),
        .MODE_REQ_READY (req_ready),
        .HSYNC          (hsync),
        .VSYNC          (vsync),
        .VGA_IF_RGBEN   (rgben),
        .FRAME_START    (frame_start),
        .MODE           (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic hs;
        logic vs;
        logic en;
        logic fs;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fs(output logic found, output logic stable);
        logic [1:0] start_mode;
        start_mode = mode;
        found  = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                found = 1'b1;
                break;
            end
            if (mode !== start_mode) stable = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       found;
        logic       stable;
        logic [1:0] exp_seq[9];
        int         vi;

        vecs[0]  = '{1,   1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{2,   1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{8,   1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{9,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{11,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{13,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{14,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{17,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{65,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{81,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{91,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{113, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{128, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{129, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        rst_n = 1'b0; enable = 1'b1; auto_en = 1'b0; req_valid = 1'b0; req = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgben", rgben, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_mode", mode, 0);
        chk("rst_ready", req_ready, 1);

        @(negedge clk) rst_n = 1'b1;
        vi = 0;
        for (int k = 1; k <= 129; k++) begin
            @(posedge clk);
            #1;
            if (vi < 14 && vecs[vi].cyc == k) begin
                chk($sformatf("vec%0d_hsync", k), hsync, vecs[vi].hs);
                chk($sformatf("vec%0d_vsync", k), vsync, vecs[vi].vs);
                chk($sformatf("vec%0d_rgben", k), rgben, vecs[vi].en);
                chk($sformatf("vec%0d_fs", k), frame_start, vecs[vi].fs);
                vi++;
            end
        end

        // mid-frame request for mode 2, second request while pending must be ignored
        @(negedge clk) begin req_valid = 1'b1; req = 2'd2; end
        @(posedge clk);
        #1;
        chk("req_ready_drop", req_ready, 0);
        @(negedge clk) req = 2'd1;
        @(posedge clk);
        @(negedge clk) req_valid = 1'b0;
        wait_fs(found, stable);
        chk("req_fs_found", found, 1);
        chk("req_mode_held", stable, 1);
        chk("req_mode_applied", mode, 2);
        chk("req_ready_back", req_ready, 1);
        wait_fs(found, stable);
        chk("req_second_ignored", mode, 2);

        // auto-rotation from reset
        @(negedge clk) begin rst_n = 1'b0; auto_en = 1'b1; end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_fs(found, stable);
            chk($sformatf("rot%0d_found", i), found, 1);
            chk($sformatf("rot%0d_mode", i), mode, exp_seq[i]);
        end

        // request lands on the boundary cycle while rotation is due
        wait_fs(found, stable);
        chk("bnd_pre_mode", mode, 0);
        repeat (127) @(posedge clk);
        @(negedge clk) begin req_valid = 1'b1; req = 2'd3; end
        @(posedge clk);
        #1;
        chk("bnd_fs", frame_start, 1);
        chk("bnd_rotated", mode, 1);
        chk("bnd_ready", req_ready, 0);
        @(negedge clk) req_valid = 1'b0;
        wait_fs(found, stable);
        chk("bnd_applied", mode, 3);

        // ENABLE low for 10 clocks inside active video
        repeat (2) @(posedge clk);
        @(negedge clk) enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_hsync", hsync, 1);
        chk("dis_vsync", vsync, 1);
        chk("dis_rgben", rgben, 0);
        chk("dis_fs", frame_start, 0);
        repeat (9) @(posedge clk);
        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        #1;
        chk("reen_fs", frame_start, 1);
        chk("reen_rgben", rgben, 1);
        chk("reen_mode", mode, 3);
        @(posedge clk);
        #1;
        chk("reen_fs_pulse", frame_start, 0);
        wait_fs(found, stable);
        chk("f_reset_mode3", mode, 3);
        wait_fs(found, stable);
        chk("f_reset_rot0", mode, 0);

        // asynchronous reset with a request pending
        @(negedge clk) begin auto_en = 1'b0; req_valid = 1'b1; req = 2'd2; end
        @(posedge clk);
        @(negedge clk) req_valid = 1'b0;
        #1;
        chk("arst_pre_ready", req_ready, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hsync", hsync, 1);
        chk("arst_vsync", vsync, 1);
        chk("arst_rgben", rgben, 0);
        chk("arst_fs", frame_start, 0);
        chk("arst_ready", req_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        wait_fs(found, stable);
        wait_fs(found, stable);
        chk("arst_found", found, 1);
        chk("arst_pend_lost", mode, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
